// File: rtl/fpnew_special_decode_pkg.sv
// Shared fpnew definitions for the binary32 operand classifier: fclass bit
// indices, format widths, the canonical NaN and the S1 decoded-field payload.
package fpnew_special_decode_pkg;

    localparam int unsigned FP32_EXP_BITS = 8;
    localparam int unsigned FP32_MAN_BITS = 23;
    localparam int unsigned CLASS_BITS    = 10;
    localparam int unsigned SNAN_CNT_W    = 16;

    // RISC-V fclass bit positions
    localparam int unsigned CLS_NEG_INF  = 0;
    localparam int unsigned CLS_NEG_NORM = 1;
    localparam int unsigned CLS_NEG_SUB  = 2;
    localparam int unsigned CLS_NEG_ZERO = 3;
    localparam int unsigned CLS_POS_ZERO = 4;
    localparam int unsigned CLS_POS_SUB  = 5;
    localparam int unsigned CLS_POS_NORM = 6;
    localparam int unsigned CLS_POS_INF  = 7;
    localparam int unsigned CLS_SNAN     = 8;
    localparam int unsigned CLS_QNAN     = 9;

    // Same value the FMA special-case path emits for invalid results
    localparam logic [31:0] CANONICAL_NAN = 32'h7FC0_0000;

    typedef struct packed {
        logic sign;
        logic exp_all_ones;
        logic exp_zero;
        logic mant_zero;
        logic mant_msb;
        logic canonical;
    } s1_fields_t;

endpackage

// File: rtl/fpnew_pipe_reg.sv
// Generic valid/ready register stage with synchronous flush; ready is
// combinational from downstream so a full pipeline still streams at one per cycle.
module fpnew_pipe_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic             valid_d, valid_q;
    logic [WIDTH-1:0] data_d, data_q;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    // Flush wins over any load; a stalled stage keeps its contents
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (in_ready_o) begin
            valid_d = in_valid_i;
            if (in_valid_i) begin
                data_d = in_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/fpnew_special_decode.sv
// Two-stage binary32 operand classifier (fclass mask, canonical NaN, sNaN flag).
// Define FPNEW_SPECIAL_DECODE_SNAN_COUNT_EN to build the saturating sNaN counter.
module fpnew_special_decode
    import fpnew_special_decode_pkg::*;
#(
    parameter int unsigned EXP_BITS  = FP32_EXP_BITS,
    parameter int unsigned MAN_BITS  = FP32_MAN_BITS,
    parameter int unsigned TAG_WIDTH = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        flush_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [EXP_BITS+MAN_BITS:0]  operand_i,
    input  logic [TAG_WIDTH-1:0]        tag_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [CLASS_BITS-1:0]       class_o,
    output logic                        canonical_nan_o,
    output logic                        nv_o,
    output logic [TAG_WIDTH-1:0]        tag_o,
    output logic [SNAN_CNT_W-1:0]       snan_count_o
);

    localparam int unsigned FP_W = 1 + EXP_BITS + MAN_BITS;
    localparam int unsigned S1_W = $bits(s1_fields_t) + TAG_WIDTH;
    localparam int unsigned S2_W = CLASS_BITS + 2 + TAG_WIDTH;
    localparam logic [MAN_BITS-1:0] QNAN_MANT = MAN_BITS'(1) << (MAN_BITS - 1);

    s1_fields_t            dec_c;
    s1_fields_t            s1_f;
    logic [TAG_WIDTH-1:0]  s1_tag;
    logic [S1_W-1:0]       s1_data;
    logic                  s1_valid;
    logic                  s2_ready;
    logic [CLASS_BITS-1:0] class_c;
    logic                  nan_c;
    logic [S2_W-1:0]       s2_data;

    // Field extraction feeding S1
    always_comb begin
        dec_c              = '0;
        dec_c.sign         = operand_i[FP_W-1];
        dec_c.exp_all_ones = &operand_i[MAN_BITS +: EXP_BITS];
        dec_c.exp_zero     = ~|operand_i[MAN_BITS +: EXP_BITS];
        dec_c.mant_zero    = ~|operand_i[MAN_BITS-1:0];
        dec_c.mant_msb     = operand_i[MAN_BITS-1];
        dec_c.canonical    = !operand_i[FP_W-1] && dec_c.exp_all_ones
                             && (operand_i[MAN_BITS-1:0] == QNAN_MANT);
    end

    fpnew_pipe_reg #(.WIDTH(S1_W)) u_s1 (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   ({dec_c, tag_i}),
        .out_valid_o (s1_valid),
        .out_ready_i (s2_ready),
        .out_data_o  (s1_data)
    );

    assign {s1_f, s1_tag} = s1_data;

    // One-hot class from the S1 fields; NaNs ignore the sign
    always_comb begin
        class_c = '0;
        nan_c   = s1_f.exp_all_ones && !s1_f.mant_zero;
        if (nan_c) begin
            class_c[CLS_QNAN] = s1_f.mant_msb;
            class_c[CLS_SNAN] = !s1_f.mant_msb;
        end else if (s1_f.exp_all_ones) begin
            class_c[CLS_NEG_INF] = s1_f.sign;
            class_c[CLS_POS_INF] = !s1_f.sign;
        end else if (s1_f.exp_zero && s1_f.mant_zero) begin
            class_c[CLS_NEG_ZERO] = s1_f.sign;
            class_c[CLS_POS_ZERO] = !s1_f.sign;
        end else if (s1_f.exp_zero) begin
            class_c[CLS_NEG_SUB] = s1_f.sign;
            class_c[CLS_POS_SUB] = !s1_f.sign;
        end else begin
            class_c[CLS_NEG_NORM] = s1_f.sign;
            class_c[CLS_POS_NORM] = !s1_f.sign;
        end
    end

    fpnew_pipe_reg #(.WIDTH(S2_W)) u_s2 (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (s1_valid),
        .in_ready_o  (s2_ready),
        .in_data_i   ({class_c, s1_f.canonical, class_c[CLS_SNAN], s1_tag}),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (s2_data)
    );

    assign {class_o, canonical_nan_o, nv_o, tag_o} = s2_data;

`ifdef FPNEW_SPECIAL_DECODE_SNAN_COUNT_EN
    logic [SNAN_CNT_W-1:0] snan_count_d, snan_count_q;

    // Counts delivered sNaN results, saturating; flush does not clear it
    always_comb begin
        snan_count_d = snan_count_q;
        if (out_valid_o && out_ready_i && nv_o && !(&snan_count_q)) begin
            snan_count_d = snan_count_q + SNAN_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            snan_count_q <= '0;
        end else begin
            snan_count_q <= snan_count_d;
        end
    end

    assign snan_count_o = snan_count_q;
`else
    assign snan_count_o = 16'h0000;
`endif

endmodule

// File: tb/tb_fpnew_special_decode.sv
// Scoreboard bench for fpnew_special_decode; expected results are queued on
// input handshake and compared on output handshake.
module tb_fpnew_special_decode;

    typedef struct {
        logic [9:0] cls;
        logic       canon;
        logic       nv;
        logic [3:0] tag;
        int         cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] operand;
    logic [3:0]  tag_in;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  class_out;
    logic        canon_out;
    logic        nv_out;
    logic [3:0]  tag_out;
    logic [15:0] snan_count;

    exp_t        sb_q[$];
    logic [9:0]  cur_cls;
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic        accepted;
    logic        lat_chk = 1'b0;
    logic        rand_ready = 1'b0;
    logic [15:0] snan_model = 16'h0;

    always #5 clk = ~clk;

    fpnew_special_decode dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .flush_i         (flush),
        .in_valid_i      (in_valid),
        .in_ready_o      (in_ready),
        .operand_i       (operand),
        .tag_i           (tag_in),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .class_o         (class_out),
        .canonical_nan_o (canon_out),
        .nv_o            (nv_out),
        .tag_o           (tag_out),
        .snan_count_o    (snan_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [9:0] ref_class(input logic [31:0] op);
        logic       s;
        logic [7:0] e;
        logic [22:0] m;
        s = op[31];
        e = op[30:23];
        m = op[22:0];
        if (e == 8'hFF && m != 0) return m[22] ? 10'h200 : 10'h100;
        if (e == 8'hFF)           return s ? 10'h001 : 10'h080;
        if (e == 0 && m == 0)     return s ? 10'h008 : 10'h010;
        if (e == 0)               return s ? 10'h004 : 10'h020;
        return s ? 10'h002 : 10'h040;
    endfunction

    // One clock: evaluate both handshakes at mid-cycle, then advance to the next negedge
    task automatic cycle();
        exp_t e;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        #1;
        accepted = 1'b0;
        if (in_valid && in_ready && !flush) begin
            accepted = 1'b1;
            e.cls   = cur_cls;
            e.canon = (operand == 32'h7FC0_0000);
            e.nv    = cur_cls[8];
            e.tag   = tag_in;
            e.cyc   = cyc;
            sb_q.push_back(e);
        end
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_out", 32'(out_valid), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("class", 32'(class_out), 32'(e.cls));
                check("canon", 32'(canon_out), 32'(e.canon));
                check("nv", 32'(nv_out), 32'(e.nv));
                check("tag", 32'(tag_out), 32'(e.tag));
                if (lat_chk) check("latency", 32'(cyc - e.cyc), 32'd2);
`ifdef FPNEW_SPECIAL_DECODE_SNAN_COUNT_EN
                if (e.nv && snan_model != 16'hFFFF) snan_model++;
`endif
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic send(input logic [31:0] op, input logic [3:0] tg, input logic [9:0] cls);
        int n;
        operand  = op;
        tag_in   = tg;
        cur_cls  = cls;
        in_valid = 1'b1;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!accepted && n < 200);
        if (!accepted) check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        n = 0;
        while ((sb_q.size() != 0 || out_valid) && n < 100) begin
            cycle();
            n++;
        end
        for (int i = 0; i < 4; i++) cycle();
        check("drain_empty", 32'(sb_q.size()), 32'd0);
        check("snan_count", 32'(snan_count), 32'(snan_model));
    endtask

    initial begin
        logic [31:0] op;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        operand = '0; tag_in = '0; cur_cls = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_class", 32'(class_out), 32'd0);
        check("rst_canon", 32'(canon_out), 32'd0);
        check("rst_nv", 32'(nv_out), 32'd0);
        check("rst_tag", 32'(tag_out), 32'd0);
        check("rst_snan_count", 32'(snan_count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // Canonical NaN, then four back-to-back specials with tags 1-4
        lat_chk = 1'b1;
        send(32'h7FC0_0000, 4'd0, 10'h200);
        drain();
        in_valid = 1'b1;
        send(32'h7F80_0001, 4'd1, 10'h100);
        send(32'hFF80_0000, 4'd2, 10'h001);
        send(32'h8000_0000, 4'd3, 10'h008);
        send(32'h0000_0001, 4'd4, 10'h020);
        drain();
        send(32'h7FC0_0001, 4'd5, 10'h200);
        send(32'hFFC0_0000, 4'd6, 10'h200);
        send(32'h3F80_0000, 4'd7, 10'h040);
        send(32'h7F80_0000, 4'd8, 10'h080);
        send(32'h0000_0000, 4'd9, 10'h010);
        send(32'h807F_FFFF, 4'd10, 10'h004);
        send(32'hC000_0000, 4'd11, 10'h002);
        drain();
        lat_chk = 1'b0;

        // Backpressure: two fit, third is refused until downstream frees up
        out_ready = 1'b0;
        send(32'h4000_0000, 4'd1, 10'h040);
        send(32'hFF80_0001, 4'd2, 10'h100);
        operand = 32'h0040_0000; tag_in = 4'd3; cur_cls = 10'h020; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_stall_valid", 32'(out_valid), 32'd1);
            check("bp_stall_class", 32'(class_out), 32'(sb_q[0].cls));
            check("bp_stall_tag", 32'(tag_out), 32'(sb_q[0].tag));
            cycle();
            check("bp_no_accept", 32'(accepted), 32'd0);
        end
        out_ready = 1'b1;
        send(32'h0040_0000, 4'd3, 10'h020);
        drain();

        // Flush with both stages full and a new operand offered
        out_ready = 1'b0;
        send(32'h7F80_0002, 4'd4, 10'h100);
        send(32'h3F80_0000, 4'd5, 10'h040);
        operand = 32'hBF80_0000; tag_in = 4'd6; cur_cls = 10'h002;
        in_valid = 1'b1; flush = 1'b1;
        cycle();
        sb_q.delete();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("flush_out_valid", 32'(out_valid), 32'd0);
        drain();

        // Random stream with random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            op = $urandom();
            case ($urandom_range(0, 4))
                0: op[30:23] = 8'hFF;
                1: op[30:23] = 8'h00;
                2: op[22:0]  = '0;
                default: ;
            endcase
            send(op, 4'($urandom_range(0, 15)), ref_class(op));
        end
        rand_ready = 1'b0;
        drain();

`ifdef FPNEW_SPECIAL_DECODE_SNAN_COUNT_EN
        // Stream sNaNs until the counter saturates
        operand = 32'hFFA0_0000; tag_in = 4'd7; cur_cls = 10'h100;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 65540; i++) cycle();
        drain();
        check("snan_saturated", 32'(snan_count), 32'h0000_FFFF);
`else
        check("snan_count_off", 32'(snan_count), 32'd0);
`endif

        // Reset with both stages full
        out_ready = 1'b0;
        send(32'h7F80_0001, 4'd8, 10'h100);
        send(32'h7F80_0003, 4'd9, 10'h100);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_class", 32'(class_out), 32'd0);
        check("midrst_nv", 32'(nv_out), 32'd0);
        check("midrst_snan_count", 32'(snan_count), 32'd0);
        sb_q.delete();
        snan_model = 16'h0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fpnew_special_decode.md
# fpnew_special_decode

Pipelined IEEE-754 binary32 operand classifier, the decode-side counterpart of the FMA special-case result generator. It sits in front of the FPU writeback and classification paths. For each operand it produces a one-hot RISC-V fclass mask, a canonical-NaN indication and an invalid-operation (sNaN) flag. A two-stage valid/ready pipeline carries a tag alongside each operand and supports backpressure and flush.

## Interface
- EXP_BITS, 8, exponent width
- MAN_BITS, 23, mantissa width; operand width is 1+EXP_BITS+MAN_BITS
- TAG_WIDTH, 4, width of the opaque tag carried with each operand
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- flush_i  in  1  synchronous pipeline flush
- in_valid_i  in  1  operand valid
- in_ready_o  out  1  operand accepted when in_valid_i && in_ready_o
- operand_i  in  32  binary32 operand {sign, exp, mant}
- tag_i  in  TAG_WIDTH  tag for the operand
- out_valid_o  out  1  result valid
- out_ready_i  in  1  downstream ready
- class_o  out  10  one-hot fclass mask
- canonical_nan_o  out  1  operand equals 0x7FC00000
- nv_o  out  1  operand is a signaling NaN
- tag_o  out  TAG_WIDTH  tag of the result
- snan_count_o  out  16  saturating count of sNaN results delivered

## Operation
- Stage 1 (S1) registers sign, exp_all_ones, exp_zero, mant_zero, mant_msb, canonical flag and tag.
- Stage 2 (S2) registers class_o, canonical_nan_o, nv_o and tag_o, all formed from S1.
- class_o bits: 0 −inf, 1 −normal, 2 −subnormal, 3 −zero, 4 +zero, 5 +subnormal, 6 +normal, 7 +inf, 8 sNaN, 9 qNaN.
- NaN is exp all ones with mant≠0. qNaN has mant MSB=1; sNaN has mant MSB=0 and mant≠0. NaNs ignore sign.
- nv_o = class_o[8]. canonical_nan_o requires sign 0, exp all ones and mant 0x400000 exactly. Any other NaN gives canonical_nan_o=0.
- Each stage holds a valid bit. Stage ready = !valid || next stage ready; S2 next-ready = out_ready_i. in_ready_o = S1 ready, which is combinational through both stages.
- A stage loads only when its upstream is valid and it is ready. A stalled stage holds its data unchanged.
- flush_i clears both valid bits at the next edge and overrides any acceptance in that cycle. in_ready_o stays as computed, but an operand presented during flush is dropped.
- Reset values: all valid bits 0, out_valid_o 0, class_o 0, canonical_nan_o 0, nv_o 0, tag_o 0, snan_count_o 0. in_ready_o is 1 once reset deasserts.
- An output handshake with nv_o=1 increments snan_count_o, saturating at 0xFFFF. flush_i does not clear the counter; only rst_i does.

## Timing
- Latency is 2 cycles from the input handshake edge to out_valid_o, with out_ready_i held high.
- Throughput is one operand per cycle.
- With out_ready_i low the pipeline holds 2 operands. in_ready_o then drops, with no bubble or loss, and order is preserved.
- Outputs are stable while out_valid_o && !out_ready_i.
- Asserting rst_i mid-operation immediately clears all state. No partial result is emitted after release.

## Configuration
- FPNEW_SPECIAL_DECODE_SNAN_COUNT_EN defined: the sNaN counter is implemented as described.
- Macro undefined: no counter register is built, snan_count_o is tied to 16'h0000, and the port remains present.

## Structure
- The shared fpnew package holds:
  - the fclass bit-index constants
  - the binary32 EXP_BITS/MAN_BITS constants
  - the canonical NaN constant 0x7FC00000 (the same value the FMA special-case path emits)
  - a packed struct for the S1 decoded fields
- One sub-module is natural: fpnew_pipe_reg, a generic valid/ready register stage with flush, instantiated twice. The classification logic stays in the top module.

## Test plan
- Drive 0x7FC00000 → after 2 cycles class_o=10'h200, canonical_nan_o=1, nv_o=0.
- Drive 0x7F800001, 0xFF800000, 0x80000000 and 0x00000001 back-to-back with tags 1–4 → class_o 10'h100 (nv_o=1), 10'h001, 10'h008, 10'h020 on consecutive cycles with tags 1–4.
- Hold out_ready_i low and offer 3 operands → 2 are accepted, in_ready_o=0 on the third. Release out_ready_i → all 3 arrive in order with no duplicates.
- Fill both stages, then assert flush_i for one cycle alongside a new valid operand → out_valid_o=0 the next cycle and nothing from before or during the flush is emitted.
- With the macro defined, deliver 65537 sNaNs → snan_count_o saturates at 0xFFFF. Undefined → snan_count_o stays 0.
- Assert rst_i while both stages are full → out_valid_o and class_o go 0 at once and in_ready_o returns to 1 after release.
